// File: rtl/hit_event_scheduler_pkg.sv
// hit_pkg: shared constants and types for the per-frame hit event scheduler.
//   NUM_COLLISIONS : number of collision sources (event IDs 0..NUM_COLLISIONS-1)
//   event_e        : symbolic names of the event IDs
//   state_t        : delivery FSM state
package hit_pkg;
  localparam int NUM_COLLISIONS = 4;
  typedef enum logic [1:0] {
    EV_MON1_MISSILE    = 2'd0,
    EV_MON2_MISSILE    = 2'd1,
    EV_MON1_BOUNDARY   = 2'd2,
    EV_PLAYER_BOUNDARY = 2'd3
  } event_e;
  typedef enum logic {IDLE, OFFER} state_t;
endpackage

// File: rtl/hit_event_scheduler_rr_picker.sv
// rr_picker: combinational round-robin search of a request vector.
//   req_i   : request bits, bit k = ID k
//   start_i : first index to examine; the search wraps from N-1 to 0
//   found_o : at least one request is set
//   idx_o   : first set index at or after start_i (0 when none is set)
module rr_picker #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] start_i,
  output logic            found_o,
  output logic [ID_W-1:0] idx_o
);
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found_o && req_i[(int'(start_i) + i) % N]) begin
        found_o = 1'b1;
        idx_o   = ID_W'((int'(start_i) + i) % N);
      end
    end
  end
endmodule

// File: rtl/hit_event_scheduler.sv
// hit_event_scheduler: makes collision flags sticky per frame, snapshots them at
// frame start and delivers each pending hit once, round-robin, over valid/ack.
//   clk, resetN   : clock, asynchronous active-low reset
//   startOfFrame  : one-cycle frame-start pulse; triggers the snapshot
//   collision     : raw collision flags, bit k = event ID k
//   event_valid/event_id/event_ack : event offer handshake
//   busy          : events pending or being offered
//   overrun       : pulse when a snapshot lands on undelivered events
//   hit_count     : saturating count of delivered events
module hit_event_scheduler #(
  parameter int NUM_COLLISIONS = hit_pkg::NUM_COLLISIONS,
  parameter int ID_W           = 2,
  parameter int CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic [NUM_COLLISIONS-1:0] collision,
  output logic                      event_valid,
  output logic [ID_W-1:0]           event_id,
  input  logic                      event_ack,
  output logic                      busy,
  output logic                      overrun,
  output logic [CNT_W-1:0]          hit_count
);
  hit_pkg::state_t           state_q;
  logic [NUM_COLLISIONS-1:0] acc_q, pending_q, pending_d, snap, ack_mask, kept;
  logic [ID_W-1:0]           rr_q, nxt_ptr, pick, pick_start;
  logic                      ack_fire, found;
  assign ack_fire   = event_valid && event_ack;
  assign ack_mask   = ack_fire ? NUM_COLLISIONS'(1) << event_id : '0;
  assign snap       = startOfFrame ? acc_q | collision : '0;
  assign kept       = pending_q & ~ack_mask;
  // OR-ing the snapshot last lets a new-frame set win over a same-cycle ack clear
  assign pending_d  = kept | snap;
  assign nxt_ptr    = (event_id == ID_W'(NUM_COLLISIONS - 1)) ? '0 : event_id + 1'b1;
  // the pointer update and the next search happen on the same ack edge
  assign pick_start = ack_fire ? nxt_ptr : rr_q;
  rr_picker #(.N(NUM_COLLISIONS), .ID_W(ID_W)) u_pick (
    .req_i   (pending_d),
    .start_i (pick_start),
    .found_o (found),
    .idx_o   (pick)
  );
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= hit_pkg::IDLE;
      acc_q       <= '0;
      pending_q   <= '0;
      rr_q        <= '0;
      event_valid <= 1'b0;
      event_id    <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      hit_count   <= '0;
    end else begin
      acc_q     <= startOfFrame ? '0 : acc_q | collision;
      pending_q <= pending_d;
      overrun   <= startOfFrame && |kept;
      busy      <= |pending_d;
      if (ack_fire) rr_q <= nxt_ptr;
      if (ack_fire && !(&hit_count)) hit_count <= hit_count + 1'b1;
      case (state_q)
        hit_pkg::IDLE: if (found) begin
          state_q     <= hit_pkg::OFFER;
          event_valid <= 1'b1;
          event_id    <= pick;
        end
        hit_pkg::OFFER: if (event_ack) begin
          if (found) event_id <= pick;
          else begin
            state_q     <= hit_pkg::IDLE;
            event_valid <= 1'b0;
          end
        end
        default: state_q <= hit_pkg::IDLE;
      endcase
    end
  end
endmodule
